router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 63, giving the largest legal payload length in bytes (range 1..63).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, a packet request sampled only in IDLE.
REQ-005 SHALL have port dest_addr, input, 2 bits, the destination port (0..2), sampled with start.
REQ-006 SHALL have port payload_len, input, 6 bits, the payload byte count, sampled with start.
REQ-007 SHALL have port seed, input, 8 bits, the payload LFSR seed, sampled with start.
REQ-008 SHALL have port abort, input, 1 bit, a synchronous packet abort (router soft-reset echo).
REQ-009 SHALL have port busy, input, 1 bit, the router busy flag; a byte is accepted only on an edge with busy=0.
REQ-010 SHALL have port pkt_valid, output, 1 bit, the router pkt_valid.
REQ-011 SHALL have port data_out, output, 8 bits, the router data_in.
REQ-012 SHALL have port tx_active, output, 1 bit, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle pulse when the parity byte is accepted.
REQ-014 SHALL have port err, output, 1 bit, a one-cycle pulse when a start is rejected.

Function
REQ-015 SHALL implement FSM states IDLE, HEADER, PAYLOAD, PARITY, GAP, with all outputs registered.
REQ-016 IDLE: on start with dest_addr≤2 and 1≤payload_len≤MAX_LEN, SHALL go to HEADER next cycle, latching addr, len and seed (seed 0 replaced by 8'h01).
REQ-017 IDLE: on start with dest_addr=3 or payload_len=0 or payload_len>MAX_LEN, SHALL pulse err next cycle and stay in IDLE.
REQ-018 HEADER: SHALL drive pkt_valid=1 and data_out={len,addr}; SHALL hold both until an edge with busy=0, then enter PAYLOAD.
REQ-019 PAYLOAD: SHALL drive pkt_valid=1 and data_out=LFSR value; the first byte equals the latched seed.
REQ-020 PAYLOAD: on each edge with busy=0, SHALL advance the LFSR (shift left, bit0 = d7^d5^d4^d3) and decrement the remaining count.
REQ-021 PAYLOAD: when the last byte is accepted, SHALL go to PARITY; if busy=1, data_out and pkt_valid SHALL hold.
REQ-022 PARITY: SHALL drive pkt_valid=0 and data_out = XOR of the header and all payload bytes.
REQ-023 PARITY: on an edge with busy=0, SHALL go to GAP and pulse done.
REQ-024 GAP: SHALL last exactly one cycle with pkt_valid=0, then go to IDLE; start in GAP SHALL be ignored.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge with pkt_valid=0 and no done pulse; abort SHALL take priority over start.
REQ-026 In IDLE, data_out SHALL be 8'h00 and pkt_valid SHALL be 0.
REQ-027 The running parity SHALL be accumulated only on accepted bytes, never on held cycles.

Reset
REQ-028 While reset=1, SHALL force: state IDLE, pkt_valid=0, data_out=8'h00, tx_active=0, done=0, err=0, LFSR=8'h01, count=0, parity=0.
REQ-029 Reset asserted mid-packet SHALL drop pkt_valid immediately (asynchronously), and no done pulse SHALL follow.

Configuration
REQ-030 With macro ROUTER_PKT_TX_PARITY_ERR_INJ_EN defined, SHALL add input inject_err (1 bit); inject_err is sampled with start, and when set, the parity byte of that packet is sent with bit0 inverted.
REQ-031 Without ROUTER_PKT_TX_PARITY_ERR_INJ_EN, the port SHALL be absent and parity SHALL always be correct.

Verification
REQ-032 SHALL cover this case: start with addr=1, len=3, seed=8'hA5, busy=0 -> bytes 0D,A5,4A,95 with pkt_valid=1, then 77 with pkt_valid=0; done pulses once.
REQ-033 SHALL cover this case: same packet with busy=1 for 3 cycles after the header -> header held 4 cycles; the payload and parity sequence is unchanged.
REQ-034 SHALL cover this case: start with addr=3 or len=0 -> err=1 for one cycle, pkt_valid stays 0, tx_active stays 0.
REQ-035 SHALL cover this case: abort during the 2nd payload byte -> next cycle IDLE, pkt_valid=0, no done; a following start sends a clean packet.
REQ-036 SHALL cover this case: reset asserted mid-PAYLOAD -> pkt_valid=0 and data_out=00 without waiting for a clock edge; all outputs at reset values.
REQ-037 SHALL cover this case: with ROUTER_PKT_TX_PARITY_ERR_INJ_EN and inject_err=1 for the REQ-032 packet -> parity byte 76.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: request and router-side signals of the packet transmitter.
// Carries inject_err only when ROUTER_PKT_TX_PARITY_ERR_INJ_EN is defined.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] seed;
    logic       abort;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       err;
`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
    logic       inject_err;
`endif

    modport master (
        input  start, dest_addr, payload_len, seed, abort, busy,
`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
        input  inject_err,
`endif
        output pkt_valid, data_out, tx_active, done, err
    );

    modport slave (
        output start, dest_addr, payload_len, seed, abort, busy,
`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
        output inject_err,
`endif
        input  pkt_valid, data_out, tx_active, done, err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: sends header, LFSR payload and parity bytes to a router, honouring busy.
// Optional ROUTER_PKT_TX_PARITY_ERR_INJ_EN adds inject_err to corrupt the parity byte.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input logic             clk,
    input logic             reset,
    router_pkt_tx_if.master bus
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] par_q, par_d;
    logic       inj_q, inj_d;
    logic       pv_q, pv_d;
    logic [7:0] dout_q, dout_d;
    logic       act_q, act_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       start_ok;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign start_ok = bus.dest_addr != 2'd3 && bus.payload_len != 6'd0 &&
                      32'(bus.payload_len) <= MAX_LEN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        par_d   = par_q;
        inj_d   = inj_q;
        pv_d    = 1'b0;
        dout_d  = 8'h00;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && start_ok) begin
                    state_d = HEADER;
                    cnt_d   = bus.payload_len;
                    lfsr_d  = bus.seed == 8'h00 ? 8'h01 : bus.seed;
                    par_d   = 8'h00;
`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
                    inj_d   = bus.inject_err;
`else
                    inj_d   = 1'b0;
`endif
                    pv_d    = 1'b1;
                    dout_d  = {bus.payload_len, bus.dest_addr};
                end else begin
                    err_d = bus.start;
                end
            end
            HEADER: begin
                pv_d    = 1'b1;
                dout_d  = bus.busy ? dout_q : lfsr_q;
                par_d   = bus.busy ? par_q : par_q ^ dout_q;
                state_d = bus.busy ? HEADER : PAYLOAD;
            end
            PAYLOAD: begin
                pv_d   = 1'b1;
                dout_d = dout_q;
                if (!bus.busy) begin
                    par_d  = par_q ^ dout_q;
                    cnt_d  = cnt_q - 6'd1;
                    lfsr_d = lfsr_next(lfsr_q);
                    if (cnt_q == 6'd1) begin
                        state_d = PARITY;
                        pv_d    = 1'b0;
                        dout_d  = par_q ^ dout_q ^ {7'd0, inj_q};
                    end else begin
                        dout_d = lfsr_next(lfsr_q);
                    end
                end
            end
            PARITY: begin
                dout_d  = bus.busy ? dout_q : 8'h00;
                done_d  = !bus.busy;
                state_d = bus.busy ? PARITY : GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start seen in IDLE.
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            pv_d    = 1'b0;
            dout_d  = 8'h00;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
        act_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            lfsr_q  <= 8'h01;
            par_q   <= 8'h00;
            inj_q   <= 1'b0;
            pv_q    <= 1'b0;
            dout_q  <= 8'h00;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            par_q   <= par_d;
            inj_q   <= inj_d;
            pv_q    <= pv_d;
            dout_q  <= dout_d;
            act_q   <= act_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.pkt_valid = pv_q;
    assign bus.data_out  = dout_q;
    assign bus.tx_active = act_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: vector table plus directed sequences for busy hold, abort and async reset.
module tb_router_pkt_tx;
    localparam int MAX_LEN = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [1:0] a;
        logic [5:0] l;
        logic [7:0] sd;
        logic       ab;
        logic       b;
        logic       pv;
        logic [7:0] d;
        logic       act;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic pv, input logic [7:0] d,
                           input logic act, input logic dn, input logic er);
        chk({n, ".pkt_valid"}, {7'd0, bus.pkt_valid}, {7'd0, pv});
        chk({n, ".data_out"}, bus.data_out, d);
        chk({n, ".tx_active"}, {7'd0, bus.tx_active}, {7'd0, act});
        chk({n, ".done"}, {7'd0, bus.done}, {7'd0, dn});
        chk({n, ".err"}, {7'd0, bus.err}, {7'd0, er});
    endtask

    task automatic step(input logic s, input logic [1:0] a, input logic [5:0] l,
                        input logic [7:0] sd, input logic ab, input logic b);
        bus.start       = s;
        bus.dest_addr   = a;
        bus.payload_len = l;
        bus.seed        = sd;
        bus.abort       = ab;
        bus.busy        = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // Sends the addr=1 len=3 seed=A5 packet with busy=0 and checks every cycle.
    task automatic clean_packet(input string n, input logic [7:0] par);
        logic [7:0] exp_b[4];
        exp_b = '{8'h0D, 8'hA5, 8'h4A, 8'h95};
        step(1, 2'd1, 6'd3, 8'hA5, 0, 0);
        chk_all({n, ".hdr"}, 1, 8'h0D, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk_all($sformatf("%s.b%0d", n, i), 1, exp_b[i], 1, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk_all({n, ".par"}, 0, par, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all({n, ".gap"}, 0, 8'h00, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all({n, ".idle"}, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        bus.start = 0; bus.dest_addr = 0; bus.payload_len = 0;
        bus.seed = 0; bus.abort = 0; bus.busy = 0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
        bus.inject_err = 0;
`endif
        v[0]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0};
        v[1]  = '{1, 2'd1, 6'd3, 8'hA5, 0, 0, 1, 8'h0D, 1, 0, 0};
        v[2]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0};
        v[3]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 1, 8'h4A, 1, 0, 0};
        v[4]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 1, 8'h95, 1, 0, 0};
        v[5]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 0, 8'h77, 1, 0, 0};
        v[6]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0};
        v[7]  = '{1, 2'd1, 6'd3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0};
        v[8]  = '{1, 2'd3, 6'd3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1};
        v[9]  = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0};
        v[10] = '{1, 2'd0, 6'd0, 8'h11, 0, 0, 0, 8'h00, 0, 0, 1};
        v[11] = '{1, 2'd2, 6'd9, 8'h11, 0, 0, 0, 8'h00, 0, 0, 1};
        v[12] = '{1, 2'd0, 6'd2, 8'h11, 1, 0, 0, 8'h00, 0, 0, 0};
        v[13] = '{1, 2'd2, 6'd8, 8'h00, 0, 0, 1, 8'h22, 1, 0, 0};
        v[14] = '{0, 2'd0, 6'd0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0};
        v[15] = '{0, 2'd0, 6'd0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0};

        #2;
        chk_all("reset", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 16; i++) begin
            step(v[i].s, v[i].a, v[i].l, v[i].sd, v[i].ab, v[i].b);
            chk_all($sformatf("vec%0d", i), v[i].pv, v[i].d, v[i].act, v[i].dn, v[i].er);
        end

        step(1, 2'd1, 6'd3, 8'hA5, 0, 0);
        chk_all("busy.hdr0", 1, 8'h0D, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk_all($sformatf("busy.hdr%0d", i), 1, 8'h0D, 1, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.a5", 1, 8'hA5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk_all("busy.a5hold", 1, 8'hA5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.4a", 1, 8'h4A, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.95", 1, 8'h95, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.par", 0, 8'h77, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk_all("busy.parhold", 0, 8'h77, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.gap", 0, 8'h00, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("busy.idle", 0, 8'h00, 0, 0, 0);

        step(1, 2'd1, 6'd3, 8'hA5, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("abort.b2", 1, 8'h4A, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk_all("abort.idle", 0, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("abort.nodone", 0, 8'h00, 0, 0, 0);
        clean_packet("after_abort", 8'h77);

        step(1, 2'd1, 6'd3, 8'hA5, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("rst.pre", 1, 8'hA5, 1, 0, 0);
        reset = 1;
        #1;
        chk_all("rst.async", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        step(0, 0, 0, 0, 0, 0);
        chk_all("rst.after1", 0, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("rst.after2", 0, 8'h00, 0, 0, 0);
        clean_packet("after_rst", 8'h77);

`ifdef ROUTER_PKT_TX_PARITY_ERR_INJ_EN
        bus.inject_err = 1;
        clean_packet("inject", 8'h76);
        bus.inject_err = 0;
        clean_packet("no_inject", 8'h77);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
